mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Sits directly downstream of the cache side of the memory arbiter interface.
- Takes the icache fill request and the dcache read/write request and serializes them onto one single-ported RAM port.
- Returns the RAM result to the requester with a one-cycle hit pulse.
- Dcache has priority; a starvation counter guarantees icache forward progress.

Parameters:
STARVE_LIMIT, 4, consecutive dcache grants allowed while icache is waiting before icache is forced
RETRY_LIMIT, 3, ramstate ERROR responses tolerated per access before the access is dropped and err_flag set

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  reset, asynchronous, active-low
imemREN  in  1  icache read request, held until ihit
imemaddr  in  32  icache word address (word_t)
ihit  out  1  one-cycle pulse, imemload valid
imemload  out  32  icache read data
dmemREN  in  1  dcache read request, held until dhit
dmemWEN  in  1  dcache write request, held until dhit
dmemaddr  in  32  dcache address
dmemstore  in  32  dcache write data
dhit  out  1  one-cycle pulse, dcache access complete
dmemload  out  32  dcache read data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
err_flag  out  1  sticky: an access exhausted RETRY_LIMIT

Behaviour:
- Clock and reset: one clock CLK; nRST asynchronous active-low.
- Reset values: state=IDLE; all outputs 0; latched addr/data/op 0; starve_cnt=0; retry_cnt=0; err_flag=0.
- States: IDLE, DACC, IACC, RESP.
- IDLE, dcache request pending (dmemREN|dmemWEN):
  - If imemREN and starve_cnt==STARVE_LIMIT, grant icache.
  - Otherwise grant dcache.
- IDLE, only imemREN pending: grant icache. No request: stay in IDLE.
- Grant actions:
  - On the grant edge, latch address, store data and op; requester changes during the access are ignored.
  - dmemWEN and dmemREN both high: treated as a write.
- starve_cnt update:
  - Dcache grant with imemREN high: increment, saturating.
  - Icache grant: clear to 0.
  - Dcache grant with imemREN low: clear to 0.
- DACC/IACC, RAM drive:
  - ramREN/ramWEN/ramaddr/ramstore driven from the latched request (registered state, combinational decode).
  - ramREN and ramWEN are never both 1.
  - RAM signals are 0 in IDLE and RESP.
- DACC/IACC, ramstate outcomes:
  - ACCESS: capture ramload into imemload/dmemload (read only; a write leaves dmemload unchanged); go to RESP; retry_cnt=0.
  - ERROR: retry_cnt++ and stay. When retry_cnt reaches RETRY_LIMIT, set err_flag, go to RESP, data output=32'hBAD1BAD1.
  - BUSY or FREE: hold.
- RESP:
  - Assert ihit or dhit for exactly one cycle for the served port; go to IDLE.
  - Requesters drop their request in the cycle after the hit, so RESP prevents re-serving a stale request.
- Latency: request seen in IDLE at cycle 0 → RAM enables at cycle 1 → ACCESS at cycle k → hit at cycle k+1. With ramstate==ACCESS on first cycle, hit is at cycle 2. Back-to-back accesses have a minimum spacing of 3 cycles.
- Hold/data rules:
  - imemload/dmemload hold their last value between hits.
  - ihit and dhit are never both 1.
- Reset mid-access: immediately returns to IDLE; RAM enables drop asynchronously; no hit is issued.
- A request deasserted mid-access (protocol violation) still completes; the hit still pulses.

Decomposition:
- cpu_types_pkg gains:
  - ramstate_t (2-bit enum FREE=0, BUSY=1, ACCESS=2, ERROR=3).
  - arb_state_t (IDLE, DACC, IACC, RESP).
  - constant BAD_DATA=32'hBAD1BAD1.
- word_t is reused for all 32-bit buses.
- One natural sub-module, arb_priority_sel: combinational grant decision plus the starve_cnt register.
- The FSM and datapath latches stay in mem_req_arbiter.

Test Plan:
- Icache read: imemREN=1, imemaddr=0x100; RAM gives ACCESS on 2nd cycle with ramload=0xDEADBEEF → ramREN=1 and ramaddr=0x100 from cycle 1; ihit pulses once; imemload=0xDEADBEEF; ramWEN stays 0.
- Dcache write: dmemWEN=1, dmemaddr=0x200, dmemstore=0x12345678 → ramWEN=1, ramstore=0x12345678; dhit pulses once; dmemload unchanged.
- Simultaneous imemREN and dmemREN at 0x300/0x400 → dcache served first (ramaddr=0x400, dhit); then icache (ramaddr=0x300, ihit); hits are never coincident.
- Starvation: dcache requests continuously, icache held high, STARVE_LIMIT=4 → exactly 4 dcache grants, then 1 icache grant, then dcache resumes.
- Errors: ramstate=ERROR twice then ACCESS → access completes, err_flag=0. ERROR three times → dhit with dmemload=0xBAD1BAD1; err_flag=1 and stays set.
- Reset: assert nRST=0 while in DACC with ramWEN=1 → ramWEN=0 with no clock edge; no dhit; IDLE after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake states, arbiter states and default limits.
// Pure declarations, no logic.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        DACC,
        IACC,
        RESP
    } arb_state_t;

    localparam word_t BAD_DATA         = 32'hBAD1BAD1;
    localparam int    DEF_STARVE_LIMIT = 4;
    localparam int    DEF_RETRY_LIMIT  = 3;

endpackage

// File: rtl/arb_priority_sel.sv
// Grant decision for the RAM port: dcache first, icache forced after STARVE_LIMIT losses.
// Combinational grant, only valid while the arbiter is idle; starve_cnt updates on the grant edge.
module arb_priority_sel
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_idle,
    input  logic ireq,
    input  logic dreq,
    output logic grant_i,
    output logic grant_d
);

    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    logic [SCW-1:0] starve_cnt;
    logic           starved;

    assign starved = (starve_cnt == SCW'(STARVE_LIMIT));

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (arb_idle) begin
            if (dreq && !(ireq && starved)) begin
                grant_d = 1'b1;
            end else if (ireq) begin
                grant_i = 1'b1;
            end
        end
    end

    // Counts dcache wins only while icache is actually waiting; saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            if (!ireq) begin
                starve_cnt <= '0;
            end else if (!starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Serializes icache fills and dcache accesses onto one RAM port; request->hit is 2 cycles minimum.
// Requesters hold until their one-cycle hit; RAM BUSY/FREE stalls, ERROR retries up to RETRY_LIMIT.
module mem_req_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int RETRY_LIMIT  = DEF_RETRY_LIMIT
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      imemREN,
    input  word_t     imemaddr,
    output logic      ihit,
    output word_t     imemload,
    input  logic      dmemREN,
    input  logic      dmemWEN,
    input  word_t     dmemaddr,
    input  word_t     dmemstore,
    output logic      dhit,
    output word_t     dmemload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      err_flag
);

    localparam int RCW = $clog2(RETRY_LIMIT + 1);

    arb_state_t     state, state_nxt;
    word_t          addr_q, store_q;
    logic           wr_q, icache_q;
    logic [RCW-1:0] retry_cnt, retry_nxt;
    logic           grant_i, grant_d;
    logic           load_cap, load_bad;
    logic           active;

    arb_priority_sel #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_sel (
        .clk     (CLK),
        .rst_n   (nRST),
        .arb_idle(state == IDLE),
        .ireq    (imemREN),
        .dreq    (dmemREN | dmemWEN),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        load_cap  = 1'b0;
        load_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_i) begin
                    state_nxt = IACC;
                end else if (grant_d) begin
                    state_nxt = DACC;
                end
            end
            DACC, IACC: begin
                case (ramstate)
                    ACCESS: begin
                        load_cap  = 1'b1;
                        retry_nxt = '0;
                        state_nxt = RESP;
                    end
                    ERROR: begin
                        if (retry_cnt == RCW'(RETRY_LIMIT - 1)) begin
                            load_bad  = 1'b1;
                            retry_nxt = '0;
                            state_nxt = RESP;
                        end else begin
                            retry_nxt = retry_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            retry_cnt <= '0;
            addr_q    <= '0;
            store_q   <= '0;
            wr_q      <= 1'b0;
            icache_q  <= 1'b0;
            imemload  <= '0;
            dmemload  <= '0;
            err_flag  <= 1'b0;
        end else begin
            state     <= state_nxt;
            retry_cnt <= retry_nxt;
            if (grant_i) begin
                addr_q   <= imemaddr;
                store_q  <= '0;
                wr_q     <= 1'b0;
                icache_q <= 1'b1;
            end else if (grant_d) begin
                // A simultaneous read+write request is served as a write.
                addr_q   <= dmemaddr;
                store_q  <= dmemstore;
                wr_q     <= dmemWEN;
                icache_q <= 1'b0;
            end
            if (load_cap) begin
                if (icache_q) begin
                    imemload <= ramload;
                end else if (!wr_q) begin
                    dmemload <= ramload;
                end
            end else if (load_bad) begin
                if (icache_q) begin
                    imemload <= BAD_DATA;
                end else begin
                    dmemload <= BAD_DATA;
                end
            end
            if (load_bad) begin
                err_flag <= 1'b1;
            end
        end
    end

    // RAM drive decodes straight from state so an async reset drops the enables immediately.
    assign active   = (state == DACC) || (state == IACC);
    assign ramREN   = active && !wr_q;
    assign ramWEN   = active && wr_q;
    assign ramaddr  = active ? addr_q : '0;
    assign ramstore = ramWEN ? store_q : '0;
    assign ihit     = (state == RESP) && icache_q;
    assign dhit     = (state == RESP) && !icache_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized and directed stimulus for mem_req_arbiter, scored against a transaction-level model.
module tb_mem_req_arbiter;
    import cpu_types_pkg::*;

    localparam int STARVE = 4;
    localparam int RETRY  = 3;

    logic      CLK = 1'b0;
    logic      nRST = 1'b0;
    logic      imemREN = 1'b0;
    word_t     imemaddr = '0;
    logic      ihit;
    word_t     imemload;
    logic      dmemREN = 1'b0;
    logic      dmemWEN = 1'b0;
    word_t     dmemaddr = '0;
    word_t     dmemstore = '0;
    logic      dhit;
    word_t     dmemload;
    logic      ramREN, ramWEN;
    word_t     ramaddr, ramstore;
    word_t     ramload = '0;
    ramstate_t ramstate = FREE;
    logic      err_flag;

    always #5 CLK = ~CLK;

    mem_req_arbiter #(.STARVE_LIMIT(STARVE), .RETRY_LIMIT(RETRY)) dut (
        .CLK(CLK), .nRST(nRST),
        .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload(dmemload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err_flag(err_flag)
    );

    int    checks = 0;
    int    failures = 0;
    word_t iq[$];
    word_t dq[$];
    logic  dq_err[$];
    int    grant_log[$];
    word_t exp_mem[word_t];
    word_t ram_mem[word_t];
    word_t last_dload = '0;
    logic  err_model = 1'b0;
    int    i_busy = 0, i_errs = 0, d_busy = 0, d_errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic word_t init_val(input word_t a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    function automatic word_t rd_exp(input word_t a);
        return exp_mem.exists(a) ? exp_mem[a] : init_val(a);
    endfunction

    function automatic word_t rd_ram(input word_t a);
        return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
    endfunction

    // RAM responder plus grant-order model: new access = enables rising after an idle cycle.
    logic  p_i = 1'b0, p_d = 1'b0, p_wen = 1'b0;
    word_t p_iaddr = '0, p_daddr = '0, p_store = '0;
    bit    act = 1'b0;
    int    step = 0, nbusy = 0, nerr = 0, streak = 0, port = 0;

    always @(negedge CLK) begin
        if (!nRST) begin
            act = 1'b0;
            streak = 0;
            ramstate = FREE;
        end else if (ramREN || ramWEN) begin
            if (!act) begin
                act = 1'b1;
                step = 0;
                port = (p_d && !(p_i && streak == STARVE)) ? 1 : 0;
                chk("grant_has_req", 32'(p_i | p_d), 32'd1);
                chk("grant_addr", ramaddr, (port == 1) ? p_daddr : p_iaddr);
                chk("grant_wen", 32'(ramWEN), 32'(port == 1 && p_wen));
                chk("grant_ren", 32'(ramREN), 32'(!(port == 1 && p_wen)));
                if (ramWEN) chk("grant_store", ramstore, p_store);
                if (port == 1 && p_i) streak = (streak < STARVE) ? streak + 1 : streak;
                else streak = 0;
                grant_log.push_back(port);
                nbusy = (port == 1) ? d_busy : i_busy;
                nerr  = (port == 1) ? d_errs : i_errs;
            end
            ramload = $urandom;
            if (step < nbusy) ramstate = BUSY;
            else if (step < nbusy + nerr) ramstate = ERROR;
            else begin
                ramstate = ACCESS;
                if (ramWEN) ram_mem[ramaddr] = ramstore;
                else ramload = rd_ram(ramaddr);
            end
            step++;
        end else begin
            act = 1'b0;
            ramstate = FREE;
        end
        p_i = imemREN;
        p_d = dmemREN | dmemWEN;
        p_wen = dmemWEN;
        p_iaddr = imemaddr;
        p_daddr = dmemaddr;
        p_store = dmemstore;
    end

    // Hit monitor: pops the scoreboard whenever the DUT presents a hit.
    bit prev_hit = 1'b0;
    always @(negedge CLK) begin
        if (!nRST) begin
            prev_hit = 1'b0;
        end else begin
            if (ihit || dhit) begin
                chk("hit_exclusive", 32'(ihit & dhit), 32'd0);
                chk("hit_one_cycle", 32'(prev_hit), 32'd0);
            end
            if (ihit) begin
                if (iq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_ihit: got 1 expected 0 at %0t", $time);
                end else chk("imemload", imemload, iq.pop_front());
            end
            if (dhit) begin
                if (dq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_dhit: got 1 expected 0 at %0t", $time);
                end else begin
                    chk("dmemload", dmemload, dq.pop_front());
                    chk("err_flag", 32'(err_flag), 32'(dq_err.pop_front()));
                end
            end
            prev_hit = ihit | dhit;
        end
    end

    task automatic wait_hit(input bit dp, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(dp ? dhit : ihit) && n < 300);
        if (!(dp ? dhit : ihit)) begin
            checks++; failures++;
            $display("FAIL hit_timeout: got no %s after %0d cycles expected a hit", dp ? "dhit" : "ihit", n);
        end
    endtask

    task automatic i_txn(input word_t a, input int busy, input int errs, output int lat);
        iq.push_back(rd_exp(a));
        i_busy = busy;
        i_errs = errs;
        @(posedge CLK); #1;
        imemaddr = a;
        imemREN = 1'b1;
        wait_hit(1'b0, lat);
        lat = lat - 1;
        @(posedge CLK); #1;
        imemREN = 1'b0;
    endtask

    task automatic d_txn(input word_t a, input word_t wd, input bit wen, input bit ren,
                         input int busy, input int errs);
        word_t e;
        int    n;
        if (errs >= RETRY) e = BAD_DATA;
        else if (wen) begin
            e = last_dload;
            exp_mem[a] = wd;
        end else e = rd_exp(a);
        last_dload = e;
        if (errs >= RETRY) err_model = 1'b1;
        dq.push_back(e);
        dq_err.push_back(err_model);
        d_busy = busy;
        d_errs = errs;
        @(posedge CLK); #1;
        dmemaddr = a;
        dmemstore = wd;
        dmemWEN = wen;
        dmemREN = ren;
        wait_hit(1'b1, n);
        @(posedge CLK); #1;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    int lat, lat2, n;
    int starve_pat[6] = '{1, 1, 1, 1, 0, 1};

    initial begin
        #3;
        chk("rst_hits", {30'd0, ihit, dhit}, 32'd0);
        chk("rst_ram_en", {30'd0, ramREN, ramWEN}, 32'd0);
        chk("rst_ramaddr", ramaddr | ramstore, 32'd0);
        chk("rst_loads_err", imemload | dmemload | 32'(err_flag), 32'd0);
        repeat (2) @(posedge CLK);
        #2 nRST = 1'b1;

        // Icache read, ACCESS on the second RAM cycle: hit three cycles after the request.
        i_txn(32'h100, 1, 0, lat);
        chk("i_latency", lat, 32'd3);

        d_txn(32'h200, 32'h12345678, 1'b1, 1'b0, 0, 0);
        d_txn(32'h200, 32'h0, 1'b0, 1'b1, 2, 0);

        grant_log.delete();
        fork
            i_txn(32'h300, 0, 0, lat2);
            d_txn(32'h400, 32'h0, 1'b0, 1'b1, 0, 0);
        join
        chk("simul_count", grant_log.size(), 32'd2);
        if (grant_log.size() == 2) begin
            chk("simul_first_d", grant_log[0], 32'd1);
            chk("simul_second_i", grant_log[1], 32'd0);
        end

        // Starvation: dcache held continuously while icache waits.
        grant_log.delete();
        i_busy = 0; i_errs = 0; d_busy = 0; d_errs = 0;
        iq.push_back(rd_exp(32'h140));
        repeat (5) begin
            dq.push_back(rd_exp(32'h440));
            dq_err.push_back(err_model);
        end
        last_dload = rd_exp(32'h440);
        @(posedge CLK); #1;
        imemaddr = 32'h140; imemREN = 1'b1;
        dmemaddr = 32'h440; dmemREN = 1'b1; dmemWEN = 1'b0;
        repeat (4) wait_hit(1'b1, n);
        wait_hit(1'b0, n);
        @(posedge CLK); #1 imemREN = 1'b0;
        wait_hit(1'b1, n);
        @(posedge CLK); #1 dmemREN = 1'b0;
        chk("starve_count", grant_log.size(), 32'd6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++)
            chk("starve_order", grant_log[k], starve_pat[k]);

        d_txn(32'h480, 32'h0, 1'b0, 1'b1, 1, 2);
        d_txn(32'h484, 32'h0, 1'b0, 1'b1, 0, 3);
        d_txn(32'h488, 32'h0, 1'b0, 1'b1, 0, 0);

        // Reset in the middle of a long write access.
        d_busy = 20; d_errs = 0;
        @(posedge CLK); #1;
        dmemaddr = 32'h240; dmemstore = 32'hCAFE0001; dmemWEN = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!ramWEN && n < 10);
        chk("rst_mid_pre_wen", 32'(ramWEN), 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("rst_mid_async_wen", 32'(ramWEN), 32'd0);
        chk("rst_mid_addr", ramaddr, 32'd0);
        dmemWEN = 1'b0;
        last_dload = '0;
        err_model = 1'b0;
        repeat (2) @(posedge CLK);
        #2 nRST = 1'b1;
        repeat (4) @(negedge CLK);
        chk("rst_post_idle", {30'd0, ramREN, ramWEN}, 32'd0);
        chk("rst_post_dmemload", dmemload, 32'd0);
        chk("rst_post_err", 32'(err_flag), 32'd0);

        fork
            begin
                int g;
                for (int k = 0; k < 40; k++) begin
                    g = $urandom_range(0, 3);
                    repeat (g) @(posedge CLK);
                    i_txn(32'h1000 + ($urandom_range(0, 15) << 2), $urandom_range(0, 2),
                          $urandom_range(0, 2), lat);
                end
            end
            begin
                int g, e;
                bit w, r;
                for (int k = 0; k < 40; k++) begin
                    g = $urandom_range(0, 3);
                    repeat (g) @(posedge CLK);
                    e = ($urandom_range(0, 7) == 0) ? RETRY : $urandom_range(0, 2);
                    w = 1'($urandom_range(0, 1));
                    r = w ? 1'($urandom_range(0, 1)) : 1'b1;
                    d_txn(32'h8000 + ($urandom_range(0, 7) << 2), $urandom, w, r,
                          $urandom_range(0, 2), e);
                end
            end
        join

        repeat (4) @(negedge CLK);
        chk("iq_drained", iq.size(), 32'd0);
        chk("dq_drained", dq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
